// File: rtl/mem_ctrl_pkg.sv
// Shared types and widths for the cache-to-halfword-RAM block controller.
package mem_ctrl_pkg;

  localparam int BLOCK_W = 32;
  localparam int HALF_W  = 16;

  typedef enum logic [3:0] {
    IDLE,
    RD_LO,
    CAP_LO,
    RD_HI,
    CAP_HI,
    LOAD_DONE,
    WR_LO,
    WR_HI,
    STORE_DONE
  } state_t;

endpackage

// File: rtl/beat_counter.sv
// Per-beat wait counter: counts 0..BEAT_WAIT while enabled, cleared on every state change.
module beat_counter #(
  parameter int BEAT_WAIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [3:0] LAST = 4'(BEAT_WAIT);

  logic [3:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !done) begin
      r_count <= r_count + 4'd1;
    end
  end

  assign done = (r_count == LAST);

endmodule

// File: rtl/mem_block_ctrl.sv
// Splits 32-bit cache block loads/stores into two 16-bit beats on a synchronous RAM.
// Handshake with the cache is four-phase; stores win over simultaneous loads.
module mem_block_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int BEAT_WAIT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_req,
  input  logic               store_req,
  input  logic [ADDR_W-1:0]  address_in,
  input  logic [BLOCK_W-1:0] data_in,
  output logic [BLOCK_W-1:0] data_out,
  output logic               load_completed,
  output logic               store_completed,
  output logic               busy,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [HALF_W-1:0]  ram_wdata,
  output logic               ram_wren,
  input  logic [HALF_W-1:0]  ram_rdata
);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-3:0]   r_addr;
  logic [BLOCK_W-1:0]  r_wdata;
  logic [BLOCK_W-1:0]  r_data_out;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic                w_done;
  logic                w_cnt_en;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_hi;
  logic                w_unused_addr;

  assign w_unused_addr = &{1'b0, address_in[1:0]};
  assign w_hi          = {1'b0, r_addr, 1'b1};
  assign w_accept      = (r_state == IDLE) && (w_next != IDLE);

  beat_counter #(.BEAT_WAIT(BEAT_WAIT)) u_beat_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_next != r_state),
    .enable (w_cnt_en),
    .done   (w_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_data_out <= '0;
      r_ram_addr <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr     <= address_in[ADDR_W-1:2];
        r_wdata    <= data_in;
        r_ram_addr <= {1'b0, address_in[ADDR_W-1:2], 1'b0};
      end
      // Advance to the high halfword only once the low beat is fully finished.
      if ((r_state == CAP_LO) || ((r_state == WR_LO) && w_done)) begin
        r_ram_addr <= w_hi;
      end
      if (r_state == CAP_LO) begin
        r_data_out[HALF_W-1:0] <= ram_rdata;
      end
      if (r_state == CAP_HI) begin
        r_data_out[BLOCK_W-1:HALF_W] <= ram_rdata;
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    w_cnt_en        = 1'b0;
    busy            = 1'b1;
    load_completed  = 1'b0;
    store_completed = 1'b0;
    ram_wren        = 1'b0;
    ram_wdata       = '0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (store_req) begin
          w_next = WR_LO;
        end else if (load_req) begin
          w_next = RD_LO;
        end
      end
      RD_LO: begin
        w_cnt_en = 1'b1;
        if (w_done) w_next = CAP_LO;
      end
      CAP_LO: w_next = RD_HI;
      RD_HI: begin
        w_cnt_en = 1'b1;
        if (w_done) w_next = CAP_HI;
      end
      CAP_HI: w_next = LOAD_DONE;
      LOAD_DONE: begin
        load_completed = 1'b1;
        if (!load_req) w_next = IDLE;
      end
      WR_LO: begin
        w_cnt_en  = 1'b1;
        ram_wren  = 1'b1;
        ram_wdata = r_wdata[HALF_W-1:0];
        if (w_done) w_next = WR_HI;
      end
      WR_HI: begin
        w_cnt_en  = 1'b1;
        ram_wren  = 1'b1;
        ram_wdata = r_wdata[BLOCK_W-1:HALF_W];
        if (w_done) w_next = STORE_DONE;
      end
      STORE_DONE: begin
        store_completed = 1'b1;
        if (!store_req) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign data_out = r_data_out;
  assign ram_addr = r_ram_addr;

endmodule

// File: tb/tb_mem_block_ctrl.sv
// Directed bench for mem_block_ctrl: one instance with no beat wait, one with two wait cycles.
module tb_mem_block_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_init = 1'b1;
  always #5 clk = ~clk;

  logic        ld0 = 1'b0, st0 = 1'b0;
  logic [15:0] addr0 = '0;
  logic [31:0] din0 = '0;
  logic [31:0] dout0;
  logic        lc0, sc0, busy0, rwe0;
  logic [15:0] raddr0, rwd0, rrd0;

  logic        ld2 = 1'b0, st2 = 1'b0;
  logic [15:0] addr2 = '0;
  logic [31:0] din2 = '0;
  logic [31:0] dout2;
  logic        lc2, sc2, busy2, rwe2;
  logic [15:0] raddr2, rwd2, rrd2;

  logic [15:0] mem0 [64];
  logic [15:0] mem2 [64];

  int n_tests = 0;
  int n_fail  = 0;

  mem_block_ctrl #(.ADDR_W(16), .BEAT_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .load_req(ld0), .store_req(st0),
    .address_in(addr0), .data_in(din0), .data_out(dout0),
    .load_completed(lc0), .store_completed(sc0), .busy(busy0),
    .ram_addr(raddr0), .ram_wdata(rwd0), .ram_wren(rwe0), .ram_rdata(rrd0)
  );

  mem_block_ctrl #(.ADDR_W(16), .BEAT_WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .load_req(ld2), .store_req(st2),
    .address_in(addr2), .data_in(din2), .data_out(dout2),
    .load_completed(lc2), .store_completed(sc2), .busy(busy2),
    .ram_addr(raddr2), .ram_wdata(rwd2), .ram_wren(rwe2), .ram_rdata(rrd2)
  );

  // Synchronous RAM models; preset mem[i] = i while ram_init is high.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 64; i++) begin
        mem0[i] <= 16'(i);
        mem2[i] <= 16'(i);
      end
    end else begin
      if (rwe0) mem0[raddr0[5:0]] <= rwd0;
      if (rwe2) mem2[raddr2[5:0]] <= rwd2;
    end
    rrd0 <= mem0[raddr0[5:0]];
    rrd2 <= mem2[raddr2[5:0]];
  end

  // Waits (bounded) for a completion flag after the accepting edge; lat = -1 on timeout.
  // which: 0 = dut0 load, 1 = dut0 store, 2 = dut2 load
  task automatic wait_done(input int which, input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if ((which == 0 && lc0) || (which == 1 && sc0) || (which == 2 && lc2)) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ram_init = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (dout0 !== 32'h0) begin n_fail++; $display("FAIL reset_data_out got %h want 00000000", dout0); end
    n_tests++; if ({lc0, sc0} !== 2'b00) begin n_fail++; $display("FAIL reset_completed got %b want 00", {lc0, sc0}); end
    n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy0); end
    n_tests++; if ({rwe0, raddr0, rwd0} !== 33'h0) begin n_fail++; $display("FAIL reset_ram_if got %h want 0", {rwe0, raddr0, rwd0}); end
    @(negedge clk);
    rst = 1'b0;
    ram_init = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load();
    int lat;
    @(negedge clk); addr0 = 16'h0004; ld0 = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL load_busy got %b want 1", busy0); end
    n_tests++; if (raddr0 !== 16'd2) begin n_fail++; $display("FAIL load_lo_index got %0d want 2", raddr0); end
    @(negedge clk); addr0 = 16'h0020;
    wait_done(0, 10, lat);
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL load_latency got %0d want 4", lat); end
    n_tests++; if (dout0 !== 32'h0003_0002) begin n_fail++; $display("FAIL load_data got %h want 00030002", dout0); end
    @(negedge clk); ld0 = 1'b0;
    @(posedge clk); #1;
    n_tests++; if ({lc0, busy0} !== 2'b00) begin n_fail++; $display("FAIL load_release got %b want 00", {lc0, busy0}); end
  endtask

  task automatic test_store();
    int lat;
    @(negedge clk); addr0 = 16'h0008; din0 = 32'hDEAD_BEEF; st0 = 1'b1;
    @(posedge clk);
    @(negedge clk); din0 = 32'h0; addr0 = 16'h0030;
    wait_done(1, 10, lat);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL store_latency got %0d want 2", lat); end
    n_tests++; if (mem0[4] !== 16'hBEEF) begin n_fail++; $display("FAIL store_mem4 got %h want beef", mem0[4]); end
    n_tests++; if (mem0[5] !== 16'hDEAD) begin n_fail++; $display("FAIL store_mem5 got %h want dead", mem0[5]); end
    n_tests++; if (rwe0 !== 1'b0) begin n_fail++; $display("FAIL store_done_wren got %b want 0", rwe0); end
    @(negedge clk); st0 = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (sc0 !== 1'b0) begin n_fail++; $display("FAIL store_release got %b want 0", sc0); end
    @(negedge clk); addr0 = 16'h0008; ld0 = 1'b1;
    @(posedge clk);
    wait_done(0, 10, lat);
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL reload_latency got %0d want 4", lat); end
    n_tests++; if (dout0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL reload_data got %h want deadbeef", dout0); end
    @(negedge clk); ld0 = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_simultaneous();
    int lat;
    @(negedge clk); addr0 = 16'h000C; din0 = 32'h1234_5678; ld0 = 1'b1; st0 = 1'b1;
    @(posedge clk);
    wait_done(1, 10, lat);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL simul_store_latency got %0d want 2", lat); end
    n_tests++; if (lc0 !== 1'b0) begin n_fail++; $display("FAIL simul_load_early got %b want 0", lc0); end
    n_tests++; if ({mem0[7], mem0[6]} !== 32'h1234_5678) begin n_fail++; $display("FAIL simul_mem got %h want 12345678", {mem0[7], mem0[6]}); end
    @(negedge clk); st0 = 1'b0;
    wait_done(0, 12, lat);
    n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL simul_load_latency got %0d want 6", lat); end
    n_tests++; if (dout0 !== 32'h1234_5678) begin n_fail++; $display("FAIL simul_load_data got %h want 12345678", dout0); end
    @(negedge clk); ld0 = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_hold();
    int lat;
    @(negedge clk); addr0 = 16'h0004; ld0 = 1'b1;
    @(posedge clk);
    wait_done(0, 10, lat);
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL hold_latency got %0d want 4", lat); end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      n_tests++; if ({lc0, busy0} !== 2'b11) begin n_fail++; $display("FAIL hold_cycle%0d got %b want 11", c, {lc0, busy0}); end
    end
    @(negedge clk); ld0 = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (lc0 !== 1'b0) begin n_fail++; $display("FAIL hold_drop got %b want 0", lc0); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_tests++; if ({busy0, raddr0} !== {1'b0, 16'd3}) begin n_fail++; $display("FAIL hold_idle%0d got %h want 00003", c, {busy0, raddr0}); end
    end
    n_tests++; if (dout0 !== 32'h0003_0002) begin n_fail++; $display("FAIL hold_data got %h want 00030002", dout0); end
  endtask

  task automatic test_wait_states();
    int lat;
    @(negedge clk); addr2 = 16'h0010; ld2 = 1'b1;
    @(posedge clk);
    @(negedge clk); addr2 = 16'h0020;
    wait_done(2, 20, lat);
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL wait_latency got %0d want 8", lat); end
    n_tests++; if (dout2 !== 32'h0009_0008) begin n_fail++; $display("FAIL wait_data got %h want 00090008", dout2); end
    @(negedge clk); ld2 = 1'b0;
    @(posedge clk); #1;
    n_tests++; if ({lc2, busy2} !== 2'b00) begin n_fail++; $display("FAIL wait_release got %b want 00", {lc2, busy2}); end
  endtask

  task automatic test_reset_mid_store();
    @(negedge clk); addr0 = 16'h0000; din0 = 32'hAAAA_5555; st0 = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    n_tests++; if ({rwe0, rwd0} !== {1'b1, 16'hAAAA}) begin n_fail++; $display("FAIL midrst_wr_hi got %h want 1aaaa", {rwe0, rwd0}); end
    #1; rst = 1'b1; st0 = 1'b0;
    #1;
    n_tests++; if (dout0 !== 32'h0) begin n_fail++; $display("FAIL midrst_data_out got %h want 00000000", dout0); end
    n_tests++; if ({busy0, sc0, lc0, rwe0} !== 4'b0000) begin n_fail++; $display("FAIL midrst_flags got %b want 0000", {busy0, sc0, lc0, rwe0}); end
    n_tests++; if ({raddr0, rwd0} !== 32'h0) begin n_fail++; $display("FAIL midrst_ram_if got %h want 0", {raddr0, rwd0}); end
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (mem0[0] !== 16'h5555) begin n_fail++; $display("FAIL midrst_mem0 got %h want 5555", mem0[0]); end
    n_tests++; if (mem0[1] !== 16'h0001) begin n_fail++; $display("FAIL midrst_mem1 got %h want 0001", mem0[1]); end
    n_tests++; if ({busy0, sc0} !== 2'b00) begin n_fail++; $display("FAIL midrst_after got %b want 00", {busy0, sc0}); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_simultaneous();
    test_hold();
    test_wait_states();
    test_reset_mid_store();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
